// File: rtl/reg_fd_arb_pkg.sv
// reg_fd_arb_pkg: opcodes, FSM states and counter sizing shared by the arbiter files
package reg_fd_arb_pkg;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_INIT = 2'b11;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_OWN, ST_RELEASE} state_t;
  function automatic int burst_cnt_w(int max_burst);
    return $clog2(max_burst + 1);
  endfunction
endpackage

// File: rtl/reg_fd_arbiter_if.sv
// reg_fd_arbiter_if: requester-side bundle and shared-register control outputs
interface reg_fd_arbiter_if #(
  parameter int C_WIDTH = 16,
  parameter int C_NUM_REQ = 4
);
  logic [C_NUM_REQ-1:0] REQ, LOCK, GNT, ACK;
  logic [2*C_NUM_REQ-1:0] OP;
  logic [C_WIDTH*C_NUM_REQ-1:0] D;
  logic [C_WIDTH-1:0] REG_D;
  logic BUSY, REG_CE, REG_SCLR, REG_SSET, REG_SINIT;
  modport master (
    output REQ, LOCK, OP, D,
    input GNT, ACK, BUSY, REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT
  );
  modport slave (
    input REQ, LOCK, OP, D,
    output GNT, ACK, BUSY, REG_D, REG_CE, REG_SCLR, REG_SSET, REG_SINIT
  );
endinterface

// File: rtl/reg_fd_arbiter_rr_pick.sv
// rr_pick: first requester at or above ptr, searching upward with wrap
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          valid
);
  // scan from farthest to nearest so the closest request wins last
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) begin
        win = '0;
        win[(int'(ptr) + i) % N] = 1'b1;
      end
  end
  assign valid = |req;
endmodule

// File: rtl/reg_fd_arbiter.sv
// reg_fd_arbiter: round-robin sharing of one CE/SCLR/SSET/SINIT/D register with locked bursts
module reg_fd_arbiter
  import reg_fd_arb_pkg::*;
#(
  parameter int C_WIDTH = 16,
  parameter int C_NUM_REQ = 4,
  parameter int C_MAX_BURST = 8
) (
  input logic CLK,
  input logic SCLR,
  reg_fd_arbiter_if.slave bus
);
  localparam int IW = $clog2(C_NUM_REQ);
  localparam int CW = burst_cnt_w(C_MAX_BURST);
  state_t state, state_n;
  logic [IW-1:0] own, own_n, ptr, ptr_n, win_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic [C_NUM_REQ-1:0] win, ack, ack_n;
  logic [C_WIDTH-1:0] rd, rd_n;
  logic [3:0] ctl, ctl_n;
  logic [1:0] op;
  logic valid;
  rr_pick #(.N(C_NUM_REQ)) u_pick (.req(bus.REQ), .ptr(ptr), .win(win), .valid(valid));
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < C_NUM_REQ; i++)
      if (win[i]) win_idx = IW'(i);
  end
  assign op = bus.OP[2*int'(own) +: 2];
  // ctl packs {ce, sclr, sset, sinit}; only the owner's slices are ever selected
  always_comb begin
    state_n = state;
    own_n = own;
    ptr_n = ptr;
    cnt_n = cnt;
    ack_n = '0;
    rd_n = rd;
    ctl_n = '0;
    case (state)
      ST_INIT: begin
        ctl_n = 4'b1001;
        state_n = ST_IDLE;
      end
      ST_IDLE: if (valid) begin
        own_n = win_idx;
        state_n = ST_OWN;
      end
      ST_OWN: if (!bus.REQ[own]) state_n = ST_RELEASE;
      else begin
        ack_n[own] = 1'b1;
        ctl_n = {1'b1, op == OP_CLEAR, op == OP_SET, op == OP_INIT};
        rd_n = op == OP_LOAD ? bus.D[int'(own)*C_WIDTH +: C_WIDTH] : rd;
        cnt_n = cnt + CW'(1);
        state_n = (!bus.LOCK[own] || cnt_n == CW'(C_MAX_BURST)) ? ST_RELEASE : ST_OWN;
      end
      default: begin
        cnt_n = '0;
        ptr_n = own == IW'(C_NUM_REQ - 1) ? '0 : own + IW'(1);
        state_n = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge CLK)
    if (SCLR) begin
      state <= ST_INIT;
      own <= '0;
      ptr <= '0;
      cnt <= '0;
      ack <= '0;
      rd <= '0;
      ctl <= '0;
    end else begin
      state <= state_n;
      own <= own_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      ack <= ack_n;
      rd <= rd_n;
      ctl <= ctl_n;
    end
  assign bus.GNT = state == ST_OWN ? C_NUM_REQ'(1) << own : '0;
  assign bus.ACK = ack;
  assign bus.BUSY = state != ST_IDLE;
  assign bus.REG_D = rd;
  assign {bus.REG_CE, bus.REG_SCLR, bus.REG_SSET, bus.REG_SINIT} = ctl;
endmodule
